// File: rtl/fmc_adc_mezzanine_lite.sv
// Lightweight FMC ADC acquisition core: Wishbone register bank, trigger
// sources (software, delayed external, time, per-channel threshold) and a
// multishot acquisition FSM driving a sample-store strobe.
module fmc_adc_mezzanine_lite #(
    parameter int unsigned g_multishot_ram_size = 2048
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic [7:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    input  logic [63:0] adc_data_i,
    input  logic        adc_valid_i,
    input  logic        ext_trigger_i,
    input  logic        time_trig_i,
    output logic [63:0] smp_data_o,
    output logic        smp_wr_o,
    output logic [2:0]  acq_fsm_state_o,
    output logic        trig_irq_o,
    output logic        acq_end_irq_o,
    output logic        acq_cfg_ok_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd1,
        ST_PRE_TRIG  = 3'd2,
        ST_WAIT_TRIG = 3'd3,
        ST_POST_TRIG = 3'd4,
        ST_TRIG_TAG  = 3'd5,
        ST_DECR_SHOT = 3'd6
    } state_t;

    state_t      state;

    // Host-visible configuration registers
    logic [31:0] trig_en;
    logic [31:0] ext_dly;
    logic [15:0] shots_nb;
    logic [31:0] pre_samples;
    logic [31:0] post_samples;
    logic [31:0] thres [4];

    // Status / counters
    logic [15:0] remaining;
    logic [31:0] samples_cnt;
    logic [31:0] smp_cnt;

    // Copies latched at start so host writes only apply to the next acquisition
    logic [31:0] act_pre;
    logic [31:0] act_post;
    logic [31:0] act_trig_en;
    logic [31:0] act_dly;
    logic [31:0] act_thres [4];

    // Trigger path
    logic        ext_s1, ext_s2, ext_s3;
    logic        ext_edge;
    logic        dly_run;
    logic [31:0] dly_cnt;
    logic        ext_fire;
    logic [3:0]  ch_armed;
    logic [3:0]  ch_fire;
    logic [3:0]  ch_below;
    logic [3:0]  ch_ge;
    logic        trig_any;

    // Bus decode
    logic        wb_acc;
    logic        wb_wr;
    logic [5:0]  reg_sel;
    logic        start_req;
    logic        stop_req;
    logic        sw_trig;
    logic        start_go;
    logic        cfg_ok;
    logic [32:0] pre_post_sum;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign wb_stall_o      = 1'b0;
    assign wb_acc          = wb_cyc_i & wb_stb_i;
    assign wb_wr           = wb_acc & wb_we_i;
    assign reg_sel         = wb_adr_i[7:2];
    assign start_req       = wb_wr && (reg_sel == 6'h00) && wb_dat_i[0];
    assign stop_req        = wb_wr && (reg_sel == 6'h00) && wb_dat_i[1];
    assign sw_trig         = wb_wr && (reg_sel == 6'h04);
    assign pre_post_sum    = {1'b0, pre_samples} + {1'b0, post_samples};
    assign cfg_ok          = (post_samples != 32'd0) && (shots_nb != 16'd0) &&
                             ((shots_nb == 16'd1) ||
                              (pre_post_sum <= 33'(g_multishot_ram_size)));
    assign start_go        = start_req && !stop_req && (state == ST_IDLE) && cfg_ok;
    assign acq_cfg_ok_o    = cfg_ok;
    assign acq_fsm_state_o = state;
    assign ext_edge        = ext_s2 & ~ext_s3;
    assign trig_any        = (act_trig_en[2] & sw_trig) |
                             (act_trig_en[1] & ext_fire) |
                             (act_trig_en[4] & time_trig_i) |
                             (|(act_trig_en[11:8] & ch_fire));
    assign unused_ok       = ^{wb_sel_i, wb_adr_i[1:0], act_trig_en[31:12],
                               act_trig_en[7:5], act_trig_en[3], act_trig_en[0]};

    // Register write port
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            trig_en      <= 32'h4;
            ext_dly      <= '0;
            shots_nb     <= '0;
            pre_samples  <= '0;
            post_samples <= '0;
            for (int unsigned i = 0; i < 4; i++) thres[i] <= '0;
        end else if (wb_wr) begin
            case (reg_sel)
                6'h02:   trig_en      <= wb_dat_i;
                6'h03:   ext_dly      <= wb_dat_i;
                6'h05:   shots_nb     <= wb_dat_i[15:0];
                6'h06:   pre_samples  <= wb_dat_i;
                6'h07:   post_samples <= wb_dat_i;
                6'h0C, 6'h0D, 6'h0E, 6'h0F: thres[reg_sel[1:0]] <= wb_dat_i;
                default: ;
            endcase
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            6'h01:   rd_data = {26'd0, cfg_ok, 1'b1, 1'b1, state};
            6'h02:   rd_data = trig_en;
            6'h03:   rd_data = ext_dly;
            6'h05:   rd_data = {remaining, shots_nb};
            6'h06:   rd_data = pre_samples;
            6'h07:   rd_data = post_samples;
            6'h08:   rd_data = samples_cnt;
            6'h0C, 6'h0D, 6'h0E, 6'h0F: rd_data = thres[reg_sel[1:0]];
            default: rd_data = '0;
        endcase
    end

    // Single-cycle acknowledge with read data captured at accept
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_acc;
            if (wb_acc && !wb_we_i) wb_dat_o <= rd_data;
        end
    end

    // External trigger synchroniser, edge detect and programmable delay
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            ext_s1   <= 1'b0;
            ext_s2   <= 1'b0;
            ext_s3   <= 1'b0;
            dly_run  <= 1'b0;
            dly_cnt  <= '0;
            ext_fire <= 1'b0;
        end else begin
            ext_s1   <= ext_trigger_i;
            ext_s2   <= ext_s1;
            ext_s3   <= ext_s2;
            ext_fire <= 1'b0;
            // Delays of 0 and 1 both fire on the cycle after the edge
            if (dly_run) begin
                if (dly_cnt == 32'd1) begin
                    ext_fire <= 1'b1;
                    dly_run  <= 1'b0;
                end else begin
                    dly_cnt <= dly_cnt - 32'd1;
                end
            end else if (ext_edge) begin
                if (act_dly <= 32'd1) begin
                    ext_fire <= 1'b1;
                end else begin
                    dly_cnt <= act_dly - 32'd1;
                    dly_run <= 1'b1;
                end
            end
        end
    end

    // Per-channel threshold compares against the latched thresholds
    always_comb begin
        ch_below = '0;
        ch_ge    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            ch_below[i] = $signed({adc_data_i[16*i+15], adc_data_i[16*i +: 16]}) <
                          ($signed({act_thres[i][15], act_thres[i][15:0]}) -
                           $signed({1'b0, act_thres[i][31:16]}));
            ch_ge[i]    = $signed(adc_data_i[16*i +: 16]) >= $signed(act_thres[i][15:0]);
        end
    end

    // Threshold arm/fire with hysteresis, re-armed only after dropping below
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            ch_armed <= '0;
            ch_fire  <= '0;
        end else begin
            ch_fire <= '0;
            if (start_go) begin
                ch_armed <= '0;
            end else if (adc_valid_i) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (ch_armed[i] && ch_ge[i]) begin
                        ch_fire[i]  <= 1'b1;
                        ch_armed[i] <= 1'b0;
                    end else if (ch_below[i]) begin
                        ch_armed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Acquisition FSM with sample counting and registered outputs
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            samples_cnt   <= '0;
            smp_cnt       <= '0;
            act_pre       <= '0;
            act_post      <= '0;
            act_trig_en   <= '0;
            act_dly       <= '0;
            for (int unsigned i = 0; i < 4; i++) act_thres[i] <= '0;
            trig_irq_o    <= 1'b0;
            acq_end_irq_o <= 1'b0;
            smp_wr_o      <= 1'b0;
            smp_data_o    <= '0;
        end else begin
            trig_irq_o    <= 1'b0;
            acq_end_irq_o <= 1'b0;
            smp_data_o    <= adc_data_i;
            smp_wr_o      <= adc_valid_i && ((state == ST_PRE_TRIG) ||
                                             (state == ST_WAIT_TRIG) ||
                                             (state == ST_POST_TRIG));
            if (stop_req) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_go) begin
                            remaining   <= shots_nb;
                            samples_cnt <= '0;
                            smp_cnt     <= '0;
                            act_pre     <= pre_samples;
                            act_post    <= post_samples;
                            act_trig_en <= trig_en;
                            act_dly     <= ext_dly;
                            for (int unsigned i = 0; i < 4; i++) act_thres[i] <= thres[i];
                            state <= (pre_samples == 32'd0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
                        end
                    end
                    ST_PRE_TRIG: begin
                        if (act_pre == 32'd0) begin
                            state <= ST_WAIT_TRIG;
                        end else if (adc_valid_i) begin
                            if (smp_cnt + 32'd1 == act_pre) begin
                                smp_cnt <= '0;
                                state   <= ST_WAIT_TRIG;
                            end else begin
                                smp_cnt <= smp_cnt + 32'd1;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (trig_any) begin
                            trig_irq_o <= 1'b1;
                            smp_cnt    <= '0;
                            state      <= ST_POST_TRIG;
                        end
                    end
                    ST_POST_TRIG: begin
                        if (adc_valid_i) begin
                            samples_cnt <= samples_cnt + 32'd1;
                            if (smp_cnt + 32'd1 == act_post) begin
                                smp_cnt <= '0;
                                state   <= ST_TRIG_TAG;
                            end else begin
                                smp_cnt <= smp_cnt + 32'd1;
                            end
                        end
                    end
                    ST_TRIG_TAG: state <= ST_DECR_SHOT;
                    ST_DECR_SHOT: begin
                        if (remaining > 16'd1) begin
                            remaining <= remaining - 16'd1;
                            state     <= (act_pre == 32'd0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
                        end else begin
                            remaining     <= '0;
                            acq_end_irq_o <= 1'b1;
                            state         <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmc_adc_mezzanine_lite.sv
// Directed self-checking bench for fmc_adc_mezzanine_lite.
module tb_fmc_adc_mezzanine_lite;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_n_i;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_stall_o;
    logic [63:0] adc_data_i;
    logic        adc_valid_i;
    logic        ext_trigger_i;
    logic        time_trig_i;
    logic [63:0] smp_data_o;
    logic        smp_wr_o;
    logic [2:0]  acq_fsm_state_o;
    logic        trig_irq_o, acq_end_irq_o, acq_cfg_ok_o;

    int          checks   = 0;
    int          failures = 0;
    int          n_trig   = 0;
    int          n_end    = 0;
    logic [2:0]  st_log[$];
    logic [2:0]  last_st;
    logic [31:0] rd;

    always #5 sys_clk_i = ~sys_clk_i;

    fmc_adc_mezzanine_lite #(.g_multishot_ram_size(2048)) dut (
        .sys_clk_i(sys_clk_i), .sys_rst_n_i(sys_rst_n_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i),
        .ext_trigger_i(ext_trigger_i), .time_trig_i(time_trig_i),
        .smp_data_o(smp_data_o), .smp_wr_o(smp_wr_o),
        .acq_fsm_state_o(acq_fsm_state_o), .trig_irq_o(trig_irq_o),
        .acq_end_irq_o(acq_end_irq_o), .acq_cfg_ok_o(acq_cfg_ok_o)
    );

    // Advance to the next falling edge and record pulses / state changes
    task automatic step();
        @(negedge sys_clk_i);
        if (trig_irq_o === 1'b1) n_trig++;
        if (acq_end_irq_o === 1'b1) n_end++;
        if (acq_fsm_state_o !== last_st) begin
            st_log.push_back(acq_fsm_state_o);
            last_st = acq_fsm_state_o;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
        wb_adr_i = adr; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step();
        chk("wb_ack", {31'd0, wb_ack_o}, 32'd1);
        dat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
    endtask

    task automatic clear_mon();
        n_trig = 0;
        n_end  = 0;
        st_log.delete();
        last_st = acq_fsm_state_o;
        st_log.push_back(last_st);
    endtask

    initial begin
        logic [2:0] exp_seq [6];
        int         trig_idx;
        int         lat;
        int         v;

        sys_rst_n_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_we_i = 1'b0; wb_sel_i = 4'hF;
        adc_data_i = '0; adc_valid_i = 1'b0;
        ext_trigger_i = 1'b0; time_trig_i = 1'b0;
        last_st = 3'd0;
        steps(3);
        chk("rst_state", {29'd0, acq_fsm_state_o}, 32'd1);
        chk("rst_outs", {28'd0, smp_wr_o, trig_irq_o, acq_end_irq_o, acq_cfg_ok_o}, 32'd0);
        sys_rst_n_i = 1'b1;
        step();

        // Reset register values and cfg_ok
        wb_read(8'h04, rd); chk("sta_reset", rd, 32'h19);
        wb_read(8'h08, rd); chk("trig_en_reset", rd, 32'h4);
        wb_write(8'h1C, 32'd1);
        wb_write(8'h14, 32'd1);
        wb_read(8'h04, rd); chk("sta_cfg_ok", rd, 32'h39);
        chk("cfg_ok_out", {31'd0, acq_cfg_ok_o}, 32'd1);

        // Multishot size boundary: 2000+48 fits, 2000+49 does not
        wb_write(8'h14, 32'd2);
        wb_write(8'h18, 32'd2000);
        wb_write(8'h1C, 32'd48);
        chk("cfg_ok_2048", {31'd0, acq_cfg_ok_o}, 32'd1);
        wb_write(8'h1C, 32'd49);
        chk("cfg_ok_2049", {31'd0, acq_cfg_ok_o}, 32'd0);
        wb_write(8'h18, 32'd0);
        wb_write(8'h1C, 32'd1);
        wb_write(8'h14, 32'd1);

        // Trigger in IDLE is discarded
        clear_mon();
        wb_write(8'h10, 32'd1);
        steps(3);
        chk("idle_trig_ignored", n_trig, 32'd0);

        // Single shot with sw trigger; TRIG_EN cleared mid-acquisition has no effect
        clear_mon();
        wb_write(8'h00, 32'd1);
        wb_write(8'h08, 32'd0);
        steps(16);
        wb_write(8'h10, 32'd1);
        steps(3);
        chk("post_state", {29'd0, acq_fsm_state_o}, 32'd4);
        adc_data_i = 64'h0004_0003_0002_1234;
        adc_valid_i = 1'b1;
        step();
        adc_valid_i = 1'b0;
        chk("smp_wr", {31'd0, smp_wr_o}, 32'd1);
        chk("smp_data_lo", smp_data_o[31:0], 32'h0002_1234);
        steps(5);
        exp_seq = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
        chk("state_log_len", st_log.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < st_log.size()) chk("state_seq", {29'd0, st_log[i]}, {29'd0, exp_seq[i]});
        chk("single_trig_irq", n_trig, 32'd1);
        chk("single_end_irq", n_end, 32'd1);
        wb_read(8'h20, rd); chk("samples_cnt", rd, 32'd1);
        wb_write(8'h08, 32'h4);

        // Three shots, sw triggers ~500 ns apart
        wb_write(8'h14, 32'd3);
        adc_valid_i = 1'b1;
        clear_mon();
        wb_write(8'h00, 32'd1);
        for (int k = 0; k < 3; k++) begin
            steps(40);
            wb_write(8'h10, 32'd1);
            steps(4);
            wb_read(8'h14, rd);
            chk("shots_remaining", rd, {16'(2 - k), 16'd3});
        end
        adc_valid_i = 1'b0;
        chk("multi_trig_cnt", n_trig, 32'd3);
        chk("multi_end_cnt", n_end, 32'd1);
        chk("multi_idle", {29'd0, acq_fsm_state_o}, 32'd1);

        // Channel 1 threshold with hysteresis on a triangle ramp
        wb_write(8'h14, 32'd1);
        wb_write(8'h30, 32'h0100_0300);
        wb_write(8'h08, 32'h100);
        clear_mon();
        wb_write(8'h00, 32'd1);
        trig_idx = -1;
        for (int j = 0; j < 27; j++) begin
            if (trig_idx < 0) begin
                v = (j <= 13) ? (900 - 100 * j) : (-400 + 100 * (j - 13));
                adc_data_i = {48'd0, 16'(v)};
                adc_valid_i = 1'b1;
                step();
                adc_valid_i = 1'b0;
                steps(2);
                if (n_trig != 0) trig_idx = j;
            end
        end
        chk("thres_trig_index", trig_idx, 32'd25);
        chk("thres_trig_cnt", n_trig, 32'd1);
        adc_data_i = {48'd0, 16'd900};
        adc_valid_i = 1'b1;
        step();
        adc_valid_i = 1'b0;
        steps(4);
        chk("thres_end", n_end, 32'd1);

        // External trigger, delay 3, two shots; second edge inside delay ignored
        wb_write(8'h0C, 32'd3);
        wb_write(8'h08, 32'h2);
        wb_write(8'h14, 32'd2);
        adc_valid_i = 1'b1;
        wb_write(8'h00, 32'd1);
        steps(3);
        clear_mon();
        lat = 0;
        ext_trigger_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) ext_trigger_i = 1'b0;
            if (k == 2) ext_trigger_i = 1'b1;
            if (k == 3) ext_trigger_i = 1'b0;
            if (n_trig != 0 && lat == 0) lat = k;
        end
        chk("ext_latency", lat, 32'd6);
        chk("ext_single_trig", n_trig, 32'd1);
        chk("ext_no_end_yet", n_end, 32'd0);
        wb_read(8'h14, rd); chk("ext_remaining", rd, 32'h0001_0002);
        ext_trigger_i = 1'b1;
        step();
        ext_trigger_i = 1'b0;
        steps(15);
        chk("ext_second_trig", n_trig, 32'd2);
        chk("ext_end", n_end, 32'd1);
        chk("ext_idle", {29'd0, acq_fsm_state_o}, 32'd1);
        adc_valid_i = 1'b0;

        // Start with POST=0 is ignored; stop in WAIT_TRIG ends without irq
        wb_write(8'h08, 32'h4);
        wb_write(8'h14, 32'd1);
        wb_write(8'h1C, 32'd0);
        wb_write(8'h00, 32'd1);
        steps(3);
        chk("post0_idle", {29'd0, acq_fsm_state_o}, 32'd1);
        wb_write(8'h1C, 32'd1);
        clear_mon();
        wb_write(8'h00, 32'd1);
        steps(3);
        chk("wait_state", {29'd0, acq_fsm_state_o}, 32'd3);
        wb_write(8'h00, 32'd2);
        chk("stop_idle", {29'd0, acq_fsm_state_o}, 32'd1);
        chk("stop_no_end", n_end, 32'd0);
        wb_write(8'h00, 32'd1);
        steps(2);
        wb_write(8'h00, 32'd3);
        chk("stop_over_start", {29'd0, acq_fsm_state_o}, 32'd1);
        chk("stop_no_end2", n_end, 32'd0);

        // Time trigger source
        wb_write(8'h08, 32'h10);
        clear_mon();
        wb_write(8'h00, 32'd1);
        steps(2);
        time_trig_i = 1'b1;
        step();
        time_trig_i = 1'b0;
        steps(2);
        chk("time_trig", n_trig, 32'd1);
        chk("time_post_state", {29'd0, acq_fsm_state_o}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmc_adc_mezzanine_lite.md
FMC_ADC_MEZZANINE_LITE -- requirements
Module: fmc_adc_mezzanine_lite

Interface
REQ-001 SHALL have parameter g_multishot_ram_size, default 2048: maximum pre+post samples per shot when shots > 1.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- sys_clk_i, in, 1: sole clock; all logic is clocked on its rising edge.
- sys_rst_n_i, in, 1: reset, asynchronous, active-low.
- wb_adr_i, in, 8: byte address; bits [7:2] are decoded.
- wb_dat_i, in, 32: write data.
- wb_dat_o, out, 32: read data.
- wb_cyc_i, wb_stb_i, wb_we_i, in, 1 each: Wishbone pipelined handshake; wb_sel_i (in, 4) is ignored.
- wb_ack_o, out, 1: acknowledge.
- wb_stall_o, out, 1: tied 0.
- adc_data_i, in, 64: four signed 16-bit samples; ch1 in [15:0] through ch4 in [63:48].
- adc_valid_i, in, 1: sample strobe.
- ext_trigger_i, in, 1: asynchronous external trigger.
- time_trig_i, in, 1: time-trigger pulse.
- smp_data_o, out, 64: sample data to store.
- smp_wr_o, out, 1: sample store strobe.
- acq_fsm_state_o, out, 3: FSM state code.
- trig_irq_o, acq_end_irq_o, out, 1 each: 1-cycle pulses.
- acq_cfg_ok_o, out, 1: configuration valid.

Function
REQ-003 SHALL provide the following register map (byte offsets); unmapped addresses read 0 and ignore writes.
- 0x00 CTL (WO): bit0 start, bit1 stop; self-clearing.
- 0x04 STA (RO): [2:0] FSM state, [3] PLL locked (constant 1), [4] serdes synced (constant 1), [5] cfg_ok.
- 0x08 TRIG_EN (RW): bit1 ext, bit2 sw (reset 1), bit4 time, bits8-11 ch1-ch4 threshold; reset value 0x4.
- 0x0C EXT_TRIG_DLY (RW, 32 bit).
- 0x10 SW_TRIG (WO): any write generates a sw-trigger pulse.
- 0x14 SHOTS: [15:0] nb (RW); [31:16] remaining shots (RO).
- 0x18 PRE_SAMPLES (RW, 32 bit).
- 0x1C POST_SAMPLES (RW, 32 bit).
- 0x20 SAMPLES_CNT (RO).
- 0x30/0x34/0x38/0x3C CHn_TRIG_THRES: [15:0] signed value, [31:16] hysteresis.
REQ-004 SHALL assert wb_ack_o exactly one cycle after each accepted cyc&stb; reads return the register value sampled at the accept cycle.
REQ-005 cfg_ok SHALL equal (POST_SAMPLES != 0) and (SHOTS.nb != 0) and (SHOTS.nb == 1 or PRE+POST <= g_multishot_ram_size); it is combinational from the registers.
REQ-006 FSM state codes SHALL be: 1 IDLE, 2 PRE_TRIG, 3 WAIT_TRIG, 4 POST_TRIG, 5 TRIG_TAG, 6 DECR_SHOT; any other encoding returns to IDLE.
REQ-007 In IDLE, a start write with cfg_ok=1 SHALL load remaining shots from SHOTS.nb, clear SAMPLES_CNT and go to PRE_TRIG; a start write with cfg_ok=0 is ignored.
REQ-008 In PRE_TRIG, SHALL count adc_valid_i samples and go to WAIT_TRIG after PRE_SAMPLES samples (immediately if PRE_SAMPLES=0).
REQ-009 In WAIT_TRIG, SHALL go to POST_TRIG on the first enabled trigger and pulse trig_irq_o.
- Trigger sources are OR-ed: sw pulse, delayed ext, time_trig_i, channel thresholds.
- Triggers arriving in any other state are discarded.
REQ-010 External trigger SHALL be 2-FF synchronised and rising-edge detected; the trigger fires EXT_TRIG_DLY cycles after the edge (0 = next cycle).
- Edges arriving while a delay count is running are ignored.
REQ-011 Channel threshold SHALL arm when the sample < value - hysteresis and fire on the first valid sample >= value while armed, then disarm (signed 16-bit compare, 17-bit subtraction).
REQ-012 In POST_TRIG, SHALL count POST_SAMPLES valid samples, then go to TRIG_TAG for 1 cycle, then DECR_SHOT.
REQ-013 In DECR_SHOT: if remaining > 1, decrement it and go to PRE_TRIG; otherwise set remaining to 0, pulse acq_end_irq_o and go to IDLE.
REQ-014 smp_wr_o SHALL equal adc_valid_i while in PRE_TRIG, WAIT_TRIG or POST_TRIG, with smp_data_o = adc_data_i registered 1 cycle; SAMPLES_CNT increments on each post-trigger write.
REQ-015 A stop write SHALL force IDLE from any state within 1 cycle, with no acq_end_irq_o.
- Stop takes priority over a simultaneous start.
REQ-016 Register writes during acquisition SHALL take effect on the next start, except SW_TRIG and CTL.

Reset
REQ-017 On sys_rst_n_i=0, SHALL asynchronously clear all registers to 0 except TRIG_EN=0x4, set FSM to IDLE, and drive outputs to 0 (STA reads 0x19).

Verification
REQ-018 Read STA after reset -> 0x19; write POST=1, SHOTS=1 -> STA reads 0x39 and acq_cfg_ok_o=1.
REQ-019 PRE=0, POST=1, SHOTS=1, start, SW_TRIG write after 200 ns -> states 1->3->4->5->6->1; one trig_irq_o and one acq_end_irq_o; SAMPLES_CNT=1.
REQ-020 SHOTS=3 with three sw triggers 500 ns apart -> remaining shots reads 2,1,0 and a single acq_end_irq_o.
REQ-021 Enable ch1 with value 0x300, hysteresis 0x100 and a triangle ramp from -400 to +900 -> trigger on the first sample >= 768 after the ramp has dropped below 512.
REQ-022 EXT_TRIG_DLY=3, ext enabled, ext pulse train -> a single trigger 3 cycles after the synchronised first edge; SHOTS=2 ends after the second pulse.
REQ-023 Start with POST=0 -> FSM stays IDLE; stop during WAIT_TRIG -> IDLE with no acq_end_irq_o.
